// File: rtl/exec_controller.sv
// ============================================================================
// Module      : exec_controller
// Description : Fetch-stage sequencer for program load, run, single-step and
//               HALT drain. Optional breakpoint: EXEC_CTRL_BREAKPOINT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module exec_controller #(
  parameter int                   PC_W         = 8,
  parameter int                   INSTR_W      = 32,
  parameter logic [INSTR_W-1:0]   HALT_INSTR   = INSTR_W'(32'hFFFF_FFFF),
  parameter int                   DRAIN_CYCLES = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  input  logic [1:0]         cmd,
  output logic               cmd_ready,
  input  logic               load_valid,
  input  logic [INSTR_W-1:0] load_data,
  output logic               load_ready,
  input  logic [INSTR_W-1:0] if_instr,
  output logic               clk_en,
  output logic               write_en,
  output logic               imem_we,
  output logic [PC_W-1:0]    imem_waddr,
  output logic [INSTR_W-1:0] imem_wdata,
  output logic               busy,
  output logic               halted,
`ifdef EXEC_CTRL_BREAKPOINT_EN
  input  logic [PC_W-1:0]    pc,
  input  logic [PC_W-1:0]    bp_pc,
  input  logic               bp_en,
  output logic               bp_hit,
`endif
  output logic [15:0]        cycle_count
);

  localparam logic [1:0] c_CMD_LOAD  = 2'b00;
  localparam logic [1:0] c_CMD_RUN   = 2'b01;
  localparam logic [1:0] c_CMD_STEP  = 2'b10;
  localparam logic [1:0] c_CMD_ABORT = 2'b11;

  localparam int c_DRAIN_W = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);
  localparam logic [c_DRAIN_W-1:0] c_DRAIN_LOAD = c_DRAIN_W'(DRAIN_CYCLES);
  localparam logic [c_DRAIN_W-1:0] c_DRAIN_ONE  = c_DRAIN_W'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_RUN    = 3'd2,
    S_STEP   = 3'd3,
    S_DRAIN  = 3'd4,
    S_HALTED = 3'd5
  } state_t;

  state_t                 r_state;
  state_t                 w_next_state;
  logic [PC_W-1:0]        r_ptr;
  logic [PC_W-1:0]        w_ptr_next;
  logic [c_DRAIN_W-1:0]   r_drain_cnt;
  logic [c_DRAIN_W-1:0]   w_drain_next;
  logic                   w_beat;
  logic                   w_cmd_acc;
  logic                   w_halt_fetch;
  logic                   w_bp_hit;

  assign w_cmd_acc    = cmd_valid && cmd_ready;
  assign w_halt_fetch = clk_en && (if_instr == HALT_INSTR);

  always_comb begin
    w_next_state = r_state;
    w_ptr_next   = r_ptr;
    w_drain_next = r_drain_cnt;
    w_beat       = 1'b0;
    w_bp_hit     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_cmd_acc) begin
          case (cmd)
            c_CMD_LOAD: w_next_state = S_LOAD;
            c_CMD_RUN:  w_next_state = S_RUN;
            c_CMD_STEP: w_next_state = S_STEP;
            default:    w_next_state = S_IDLE;
          endcase
        end
      end
      S_LOAD: begin
        if (load_valid) begin
          w_beat     = 1'b1;
          w_ptr_next = r_ptr + PC_W'(1);
          // Top address ends the load rather than wrapping onto address 0.
          if (load_data == HALT_INSTR || r_ptr == '1) w_next_state = S_IDLE;
        end
      end
      S_RUN, S_STEP: begin
        if (w_halt_fetch) begin
          w_next_state = (DRAIN_CYCLES == 0) ? S_HALTED : S_DRAIN;
          w_drain_next = c_DRAIN_LOAD;
        end else if (r_state == S_STEP) begin
          w_next_state = S_IDLE;
`ifdef EXEC_CTRL_BREAKPOINT_EN
        end else if (bp_en && pc == bp_pc && clk_en) begin
          w_next_state = S_IDLE;
          w_bp_hit     = 1'b1;
`endif
        end else if (w_cmd_acc && cmd == c_CMD_ABORT) begin
          w_next_state = S_IDLE;
        end
      end
      S_DRAIN: begin
        // Only held here while count > 0, so clk_en stays high throughout.
        if (r_drain_cnt <= c_DRAIN_ONE) w_next_state = S_HALTED;
        if (r_drain_cnt != '0) w_drain_next = r_drain_cnt - c_DRAIN_ONE;
      end
      S_HALTED: begin
        if (w_cmd_acc && cmd == c_CMD_LOAD)  w_next_state = S_LOAD;
        if (w_cmd_acc && cmd == c_CMD_ABORT) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
    if (w_next_state == S_LOAD && r_state != S_LOAD) w_ptr_next = '0;
  end

  // Outputs are registered from the next state so they line up with r_state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_drain_cnt <= '0;
      cmd_ready   <= 1'b0;
      load_ready  <= 1'b0;
      clk_en      <= 1'b0;
      write_en    <= 1'b0;
      imem_we     <= 1'b0;
      imem_waddr  <= '0;
      imem_wdata  <= '0;
      busy        <= 1'b0;
      halted      <= 1'b0;
      cycle_count <= '0;
`ifdef EXEC_CTRL_BREAKPOINT_EN
      bp_hit      <= 1'b0;
`endif
    end else begin
      r_state     <= w_next_state;
      r_ptr       <= w_ptr_next;
      r_drain_cnt <= w_drain_next;
      cmd_ready   <= (w_next_state == S_IDLE) || (w_next_state == S_HALTED) ||
                     (w_next_state == S_RUN);
      load_ready  <= (w_next_state == S_LOAD);
      write_en    <= (w_next_state == S_LOAD);
      clk_en      <= (w_next_state == S_RUN) || (w_next_state == S_STEP) ||
                     (w_next_state == S_DRAIN);
      busy        <= !((w_next_state == S_IDLE) || (w_next_state == S_HALTED));
      halted      <= (w_next_state == S_HALTED);
      imem_we     <= w_beat;
      if (w_beat) begin
        imem_waddr <= r_ptr;
        imem_wdata <= load_data;
      end
      if (w_next_state == S_LOAD)
        cycle_count <= '0;
      else if (clk_en && cycle_count != 16'hFFFF)
        cycle_count <= cycle_count + 16'd1;
`ifdef EXEC_CTRL_BREAKPOINT_EN
      bp_hit      <= w_bp_hit;
`endif
    end
  end

`ifndef EXEC_CTRL_BREAKPOINT_EN
  logic w_unused;
  assign w_unused = w_bp_hit;
`endif

endmodule

`default_nettype wire
